// File: rtl/handshake_pipe_ready_patting.sv
// Two-entry valid/ready pipe stage with a registered master_ready: main_reg feeds the
// output, skid_reg absorbs the one beat that can arrive while downstream stalls.
module handshake_pipe_ready_patting #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              master_valid,
    input  logic [DATA_W-1:0] master_data,
    output logic              master_ready,
    output logic              slave_valid,
    output logic [DATA_W-1:0] slave_data,
    input  logic              slave_ready,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [DATA_W-1:0] main_reg;
    logic [DATA_W-1:0] main_next;
    logic [DATA_W-1:0] skid_reg;
    logic [DATA_W-1:0] skid_next;
    logic              master_ready_reg;
    logic              push;
    logic              pop;

    assign push = master_valid & master_ready_reg;
    assign pop  = slave_valid & slave_ready;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (push) begin
                    main_next  = master_data;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (push && !pop) begin
                    skid_next  = master_data;
                    state_next = ST_FULL;
                end else if (push && pop) begin
                    main_next  = master_data;
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // master_ready is low here, so only a pop can move the stage
                if (pop) begin
                    main_next  = skid_reg;
                    state_next = ST_BUSY;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_EMPTY;
            main_reg         <= '0;
            skid_reg         <= '0;
            master_ready_reg <= 1'b1;
        end else begin
            state_reg        <= state_next;
            main_reg         <= main_next;
            skid_reg         <= skid_next;
            // Registered from the next state so ready never depends combinationally on inputs
            master_ready_reg <= (state_next != ST_FULL);
        end
    end

    assign master_ready = master_ready_reg;
    assign slave_valid  = (state_reg != ST_EMPTY);
    assign slave_data   = main_reg;

    always_comb begin
        occupancy = 2'd0;
        case (state_reg)
            ST_BUSY: occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_handshake_pipe_ready_patting.sv
// Bench for handshake_pipe_ready_patting: directed scenarios plus a randomized
// valid/ready run against a two-deep queue model of the stage.
module tb_handshake_pipe_ready_patting;

    logic        clk = 1'b0;
    logic        rst;
    logic        master_valid;
    logic [31:0] master_data;
    logic        master_ready;
    logic        slave_valid;
    logic [31:0] slave_data;
    logic        slave_ready;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    // Reference: ordered queue of held beats, capacity two, ready flop = "not full after edge"
    logic [31:0] q[$];
    bit          ready_m = 1'b1;
    int          model_pops = 0;
    int          dut_pops = 0;

    handshake_pipe_ready_patting #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .master_valid (master_valid),
        .master_data  (master_data),
        .master_ready (master_ready),
        .slave_valid  (slave_valid),
        .slave_data   (slave_data),
        .slave_ready  (slave_ready),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        bit dut_pop;
        bit push_m;
        bit pop_m;
        dut_pop = slave_valid && slave_ready && !rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            ready_m = 1'b1;
        end else begin
            push_m = master_valid && ready_m;
            pop_m  = (q.size() != 0) && slave_ready;
            if (pop_m) begin
                $display("pop  %h", q[0]);
                void'(q.pop_front());
                model_pops++;
            end
            if (push_m) q.push_back(master_data);
            ready_m = (q.size() != 2);
        end
        if (dut_pop) dut_pops++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; master_valid = 1'b0; master_data = 32'hDEAD_BEEF; slave_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (slave_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", slave_valid); end
        checks++; if (slave_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", slave_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if (master_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", master_ready); end
        tick();
        checks++; if ({slave_valid, occupancy, master_ready} !== {1'b0, 2'd0, 1'b1}) begin
            errors++; $display("FAIL reset_idle: got v=%b occ=%0d rdy=%b want v=0 occ=0 rdy=1", slave_valid, occupancy, master_ready);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        slave_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            master_valid = 1'b1; master_data = vals[i];
            tick();
            checks++; if ({slave_valid, slave_data, occupancy, master_ready} !== {1'b1, vals[i], 2'd1, 1'b1}) begin
                errors++; $display("FAIL stream_%0d: got v=%b d=%h occ=%0d rdy=%b want v=1 d=%h occ=1 rdy=1",
                                   i, slave_valid, slave_data, occupancy, master_ready, vals[i]);
            end
        end
        master_valid = 1'b0;
        tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain: got occ=%0d want 0", occupancy); end
    endtask

    task automatic test_backpressure_fill();
        slave_ready = 1'b0;
        master_valid = 1'b1; master_data = 32'hA0;
        tick();
        master_data = 32'hA1;
        tick();
        checks++; if ({occupancy, master_ready, slave_data} !== {2'd2, 1'b0, 32'hA0}) begin
            errors++; $display("FAIL fill: got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=a0", occupancy, master_ready, slave_data);
        end
        master_data = 32'hA2;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({occupancy, master_ready, slave_valid, slave_data} !== {2'd2, 1'b0, 1'b1, 32'hA0}) begin
                errors++; $display("FAIL stall_%0d: got occ=%0d rdy=%b v=%b d=%h want occ=2 rdy=0 v=1 d=a0",
                                   i, occupancy, master_ready, slave_valid, slave_data);
            end
        end
    endtask

    task automatic test_drain_full();
        // master_valid with 0xA2 is still asserted from the fill scenario
        slave_ready = 1'b1;
        tick();
        checks++; if ({slave_data, master_ready, occupancy} !== {32'hA1, 1'b1, 2'd1}) begin
            errors++; $display("FAIL drain_1: got d=%h rdy=%b occ=%0d want d=a1 rdy=1 occ=1", slave_data, master_ready, occupancy);
        end
        tick();
        checks++; if ({slave_valid, slave_data, occupancy} !== {1'b1, 32'hA2, 2'd1}) begin
            errors++; $display("FAIL drain_2: got v=%b d=%h occ=%0d want v=1 d=a2 occ=1", slave_valid, slave_data, occupancy);
        end
        master_valid = 1'b0;
        tick();
        checks++; if ({slave_valid, occupancy, master_ready} !== {1'b0, 2'd0, 1'b1}) begin
            errors++; $display("FAIL drain_3: got v=%b occ=%0d rdy=%b want v=0 occ=0 rdy=1", slave_valid, occupancy, master_ready);
        end
    endtask

    task automatic test_push_pop_busy();
        slave_ready = 1'b0; master_valid = 1'b1; master_data = 32'h5;
        tick();
        checks++; if ({slave_data, occupancy} !== {32'h5, 2'd1}) begin
            errors++; $display("FAIL busy_load: got d=%h occ=%0d want d=5 occ=1", slave_data, occupancy);
        end
        master_data = 32'h6; slave_ready = 1'b1;
        tick();
        checks++; if ({slave_valid, slave_data, occupancy, master_ready} !== {1'b1, 32'h6, 2'd1, 1'b1}) begin
            errors++; $display("FAIL busy_pushpop: got v=%b d=%h occ=%0d rdy=%b want v=1 d=6 occ=1 rdy=1",
                               slave_valid, slave_data, occupancy, master_ready);
        end
        // skid_reg last loaded with 0xA1 during the fill scenario
        checks++; if (dut.skid_reg !== 32'hA1) begin errors++; $display("FAIL busy_skid: got %h want a1", dut.skid_reg); end
        master_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_full();
        slave_ready = 1'b0; master_valid = 1'b1; master_data = 32'hB0;
        tick();
        master_data = 32'hB1;
        tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rfull_fill: got occ=%0d want 2", occupancy); end
        rst = 1'b1; master_data = 32'hB2; slave_ready = 1'b1;
        tick();
        rst = 1'b0; master_valid = 1'b0;
        checks++; if ({slave_valid, occupancy, master_ready, slave_data} !== {1'b0, 2'd0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL rfull_reset: got v=%b occ=%0d rdy=%b d=%h want v=0 occ=0 rdy=1 d=0",
                               slave_valid, occupancy, master_ready, slave_data);
        end
        tick();
        checks++; if (slave_valid !== 1'b0) begin errors++; $display("FAIL rfull_idle: got v=%b want 0", slave_valid); end
    endtask

    task automatic test_random_scoreboard();
        int          cyc;
        logic [31:0] exp_d;
        logic [31:0] act_d;
        bit          exp_v;
        int          start_pops;
        cyc = 0;
        start_pops = model_pops;
        while ((model_pops - start_pops) < 10000 && cyc < 40000) begin
            master_valid = ($urandom_range(0, 3) != 0);
            master_data  = {16'h8000 | cyc[15:0], 16'($urandom)};
            slave_ready  = ($urandom_range(0, 3) != 0);
            tick();
            exp_v = (q.size() != 0);
            exp_d = exp_v ? q[0] : 32'h0;
            act_d = exp_v ? slave_data : 32'h0;
            checks++; if ({slave_valid, act_d, occupancy, master_ready} !== {exp_v, exp_d, 2'(q.size()), ready_m}) begin
                errors++; $display("FAIL rand_cyc%0d: got v=%b d=%h occ=%0d rdy=%b want v=%b d=%h occ=%0d rdy=%b",
                                   cyc, slave_valid, slave_data, occupancy, master_ready, exp_v, exp_d, q.size(), ready_m);
            end
            if (slave_valid && (slave_data == 32'hB0 || slave_data == 32'hB1)) begin
                checks++; errors++; $display("FAIL rand_stale: got d=%h want no pre-reset beat", slave_data);
            end
            cyc++;
        end
        checks++; if ((model_pops - start_pops) < 10000) begin
            errors++; $display("FAIL rand_timeout: got %0d beats want 10000", model_pops - start_pops);
        end
        checks++; if (dut_pops !== model_pops) begin
            errors++; $display("FAIL rand_popcount: got %0d want %0d", dut_pops, model_pops);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure_fill();
        test_drain_full();
        test_push_pop_busy();
        test_reset_in_full();
        test_random_scoreboard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
